// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// stream framing constants and small state-decode helpers.
package loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_e;

    // States in which the loader consumes a byte from the host stream.
    function automatic logic accepts_bytes(input state_e s);
        return s inside {LEN0, LEN1, DATA, CHECK};
    endfunction

    function automatic logic is_busy(input state_e s);
        return s inside {LEN0, LEN1, DATA, WRITE, CHECK};
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in lane k.
// word_o already includes the byte being loaded this cycle.
module word_packer
    import loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          load_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          last_o
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (clear_i) begin
            idx_q <= '0;
        end else if (load_i) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign last_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] lane_q;
            logic       lane_hit;

            assign lane_hit = load_i && (idx_q == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else if (clear_i) begin
                    lane_q <= '0;
                end else if (lane_hit) begin
                    lane_q <= byte_i;
                end
            end

            // Bypass lets the caller capture a full word on the 4th byte's edge.
            assign word_o[8*gi +: 8] = lane_hit ? byte_i : lane_q;
        end
    endgenerate

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the core
// in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e LAST_WORD_NEXT = CHECK;
`else
    localparam state_e LAST_WORD_NEXT = DONE;
`endif

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [15:0]       count_inc;

    logic              pk_clear;
    logic              pk_load;
    logic              pk_last;
    logic [31:0]       pk_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign byte_ready = accepts_bytes(state_q);
    assign accept     = byte_valid && byte_ready;
    assign n_full     = {byte_data, n_q[7:0]};
    assign count_inc  = count_q + 16'd1;

    word_packer u_packer (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .byte_i  (byte_data),
        .word_o  (pk_word),
        .last_o  (pk_last)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        if (accept) begin
            csum_d = csum_q ^ byte_data;
        end
`endif

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (load_start) begin
                    state_d  = LEN0;
                    n_d      = '0;
                    count_d  = '0;
                    addr_d   = '0;
                    pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end

            LEN0: begin
                if (accept) begin
                    n_d[7:0] = byte_data;
                    state_d  = LEN1;
                end
            end

            LEN1: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(n_full) > 32'(DEPTH)) begin
                        // Rejecting oversize images keeps imem_addr inside DEPTH.
                        state_d = ERROR;
                    end else begin
                        state_d  = DATA;
                        pk_clear = 1'b1;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    pk_load = 1'b1;
                    if (pk_last) begin
                        wdata_d = pk_word;
                        addr_d  = count_q[ADDR_W-1:0];
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == n_q) ? LAST_WORD_NEXT : DATA;
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = ((csum_q ^ byte_data) == 8'h00) ? DONE : ERROR;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = is_busy(state_q);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERROR);
    assign core_hold  = (state_q != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal loads, empty and oversize headers,
// full-depth image, stalled source, mid-load reset and (optionally) checksum.
module tb_program_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          wr_base;
    int          last_addr = -1;
    logic [31:0] mem_tb [DEPTH];
    logic [7:0]  csum = 8'h00;
    bit          gaps = 1'b0;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: records every strobe and checks the source is stalled.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            mem_tb[imem_addr] = imem_wdata;
            wr_count++;
            last_addr = int'(imem_addr);
            $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
            check("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
        end
    end

    function automatic logic [31:0] word_of(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 0) return 32'h00500013;
        if (i == 1) return 32'h00A00093;
        return {8'hA5, b, ~b, 8'h5A};
    endfunction

    task automatic pulse_start();
        load_start = 1'b1;
        csum = 8'h00;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_accept_timeout", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        csum = csum ^ b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic load_image(input int n, input bit append_ck);
        logic [15:0] nn;
        logic [7:0]  c;
        nn = 16'(n);
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++) send_word(word_of(i));
`ifdef LOADER_CHECKSUM_EN
        if (append_ck && n > 0) begin
            c = csum;
            send_byte(c);
        end
`else
        c = 8'h00;
        if (append_ck && c != 8'h00) send_byte(c);
`endif
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, done | err}, 32'd1);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_core_hold", {31'b0, core_hold}, 32'd1);
        check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_imem_we", {31'b0, imem_we}, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done_err", {30'b0, done, err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready_low", {31'b0, byte_ready}, 32'd0);

        // Case 1: two-word image
        wr_base = wr_count;
        pulse_start();
        check("c1_busy", {31'b0, busy}, 32'd1);
        check("c1_ready", {31'b0, byte_ready}, 32'd1);
        check("c1_hold", {31'b0, core_hold}, 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        check("c1_we_latency", {31'b0, imem_we}, 32'd1);
        check("c1_addr0", 32'(imem_addr), 32'd0);
        check("c1_wdata0", imem_wdata, 32'h00500013);
        check("c1_ready_in_write", {31'b0, byte_ready}, 32'd0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'hA0); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h72);
`endif
        wait_end("c1_end_timeout", 20);
        check("c1_done", {31'b0, done}, 32'd1);
        check("c1_hold_released", {31'b0, core_hold}, 32'd0);
        check("c1_busy_low", {31'b0, busy}, 32'd0);
        check("c1_mem0", mem_tb[0], 32'h00500013);
        check("c1_mem1", mem_tb[1], 32'h00A00093);
        check("c1_nwrites", 32'(wr_count - wr_base), 32'd2);
        check("c1_wdata_holds", imem_wdata, 32'h00A00093);

        // Case 2: empty image
        wr_base = wr_count;
        pulse_start();
        check("c2_done_cleared", {31'b0, done}, 32'd0);
        check("c2_hold_set", {31'b0, core_hold}, 32'd1);
        send_byte(8'h00); send_byte(8'h00);
        wait_end("c2_end_timeout", 3);
        check("c2_done", {31'b0, done}, 32'd1);
        check("c2_nwrites", 32'(wr_count - wr_base), 32'd0);

        // Case 3: oversize header N = DEPTH+1
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        wait_end("c3_end_timeout", 3);
        repeat (2) @(negedge clk);
        check("c3_err", {31'b0, err}, 32'd1);
        check("c3_done", {31'b0, done}, 32'd0);
        check("c3_hold", {31'b0, core_hold}, 32'd1);
        check("c3_ready", {31'b0, byte_ready}, 32'd0);
        check("c3_nwrites", 32'(wr_count - wr_base), 32'd0);

        // Full-depth image from ERROR; a load_start mid-load must be ignored
        wr_base = wr_count;
        pulse_start();
        check("full_err_cleared", {31'b0, err}, 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_word(word_of(i));
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] c;
            c = csum;
            send_byte(c);
        end
`endif
        wait_end("full_end_timeout", 20);
        check("full_done", {31'b0, done}, 32'd1);
        check("full_nwrites", 32'(wr_count - wr_base), 32'd256);
        check("full_last_addr", 32'(last_addr), 32'd255);
        check("full_mem2", mem_tb[2], 32'hA502FD5A);
        check("full_mem255", mem_tb[255], 32'hA5FF005A);

        // Case 4: random source gaps
        mem_tb[0] = 'x;
        mem_tb[1] = 'x;
        wr_base = wr_count;
        gaps = 1'b1;
        pulse_start();
        load_image(2, 1'b1);
        gaps = 1'b0;
        wait_end("c4_end_timeout", 20);
        check("c4_done", {31'b0, done}, 32'd1);
        check("c4_mem0", mem_tb[0], 32'h00500013);
        check("c4_mem1", mem_tb[1], 32'h00A00093);
        check("c4_nwrites", 32'(wr_count - wr_base), 32'd2);

        // Case 5: reset after five data bytes, then a clean reload
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h93);
        #2 reset = 1'b0;
        #1;
        check("c5_hold", {31'b0, core_hold}, 32'd1);
        check("c5_ready", {31'b0, byte_ready}, 32'd0);
        check("c5_we", {31'b0, imem_we}, 32'd0);
        check("c5_addr", 32'(imem_addr), 32'd0);
        check("c5_wdata", imem_wdata, 32'd0);
        check("c5_flags", {29'b0, busy, done, err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_base = wr_count;
        pulse_start();
        load_image(2, 1'b1);
        wait_end("c5_end_timeout", 20);
        check("c5_done", {31'b0, done}, 32'd1);
        check("c5_mem1", mem_tb[1], 32'h00A00093);
        check("c5_nwrites", 32'(wr_count - wr_base), 32'd2);

`ifdef LOADER_CHECKSUM_EN
        // Case 6: trailing checksum byte, good then bad
        pulse_start();
        load_image(2, 1'b0);
        send_byte(8'h72);
        wait_end("c6_good_timeout", 20);
        check("c6_good_done", {31'b0, done}, 32'd1);
        pulse_start();
        load_image(2, 1'b0);
        send_byte(8'h20);
        wait_end("c6_bad_timeout", 20);
        check("c6_bad_err", {31'b0, err}, 32'd1);
        check("c6_bad_hold", {31'b0, core_hold}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
